scan_cfg_loader: RTL and testbench
==================================

# scan_cfg_loader

- Drives the fabric configuration scan chain from the chip side.
- Accepts 32-bit configuration words over a valid/ready handshake and serializes them LSB-first onto the chain input, asserting scan enable only on cycles that carry a valid bit.
- Then recirculates the whole chain once through itself, so the chain ends up holding the same contents. During recirculation it CRCs the bits returning from the chain output and compares that CRC with the one taken during load.
- Sits between the configuration host port and the `conn_scan_in` / `conn_scan_out` / `conn_scan_en` pins of the fabric top level.

## Interface
Parameters:
- `CHAIN_LEN`, 1024: total configuration bits in the chain (≥ 1).
- `WORD_W`, 32: configuration word width.

Ports:
- `scan_clk` in 1: the single clock, shared with the fabric scan cells.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse; begins a load. Honoured only in IDLE.
- `cfg_data` in `WORD_W`: configuration word; bit 0 is shifted first.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: loader accepts `cfg_data` this cycle.
- `scan_en` out 1: to the fabric `conn_scan_en`; chain shifts on each `scan_clk` edge where it is high.
- `scan_out` out 1: to the fabric `conn_scan_in`.
- `scan_in` in 1: from the fabric `conn_scan_out` (chain tail).
- `busy` out 1: high in LOAD and VERIFY.
- `done` out 1: one-cycle pulse at the end of VERIFY.
- `pass` out 1: held result of the last verify; 1 means the CRCs matched.

## Operation
- Word count: `NWORDS = ceil(CHAIN_LEN/WORD_W)`. The last word contributes `CHAIN_LEN − WORD_W·(NWORDS−1)` bits; its upper bits are discarded.
- Datapath: a `WORD_W` shifter, a `bits_left` counter, a `words_acc` counter, a chain bit counter `cnt`, and a CRC-16-CCITT generator with its saved value `crc_load`.
- CRC definition: polynomial 0x1021, init 0xFFFF. Per bit, `fb = crc[15] ^ bit`, then `crc = {crc[14:0],1'b0} ^ (fb ? 0x1021 : 0)`.
- **IDLE**
  - `scan_en=0`, `cfg_ready=0`.
  - On `start`: clear the counters, set the CRC to 0xFFFF, clear `pass`, go to LOAD.
- **LOAD**
  - `cfg_ready = (words_acc < NWORDS) && (bits_left <= 1)`.
  - On a handshake (`cfg_valid && cfg_ready`): load the shifter; `bits_left` gets `WORD_W`, or the tail count for the last word; `words_acc++`.
  - Each cycle with `bits_left > 0`:
    - `scan_en=1` and `scan_out=shifter[0]`;
    - shift the shifter right, `bits_left--`, `cnt++`;
    - feed `shifter[0]` into the CRC.
  - With `bits_left = 0`: `scan_en=0` and the chain holds (a stall).
  - When `cnt` reaches `CHAIN_LEN`: latch the CRC into `crc_load`, reset the CRC to 0xFFFF, set `cnt=0`, go to VERIFY.
- **VERIFY**
  - `scan_en=1` every cycle.
  - `scan_out = scan_in` (combinational loopback).
  - Feed `scan_in` into the CRC each cycle; `cnt++`.
  - After `CHAIN_LEN` cycles: `pass <= (crc == crc_load)`, go to DONE.
- **DONE**: `done=1` for one cycle, then IDLE.
- Boundary conditions:
  - `start` while busy is ignored.
  - Handshakes beyond `NWORDS` words cannot occur, because `cfg_ready` is 0.
  - `cfg_valid` low mid-load stalls with `scan_en=0`; no bits are lost or duplicated.
  - `CHAIN_LEN < WORD_W`: one word is used, holding `CHAIN_LEN` bits.
  - Reset mid-operation: return to IDLE with all outputs at 0. Chain contents are then undefined and the host must reload.

## Timing
- Reset values: `cfg_ready=0`, `scan_en=0`, `scan_out=0`, `busy=0`, `done=0`, `pass=0`; state is IDLE.
- In LOAD, `scan_en` and `scan_out` are registered outputs. The fabric samples them at the next `scan_clk` edge.
- In VERIFY, `scan_en` is driven from state; `scan_out` is the combinational `scan_in`.
- The state after a `start` pulse at edge N:
  - edge N+1: LOAD with `cfg_ready=1`;
  - the first bit goes out the cycle after the first handshake.
- With `cfg_valid` held high there are no bubbles: LOAD lasts `CHAIN_LEN+1` cycles.
- VERIFY lasts exactly `CHAIN_LEN` cycles.
- `done` rises the cycle after the last VERIFY shift.
- End-to-end latency: `start` to `done` = `2·CHAIN_LEN+3` cycles when the source does not stall.
- The back-to-back handshake is accepted on the cycle the previous word's final bit shifts (`bits_left==1`).

## Structure
- Shared package `scan_cfg_pkg` holds:
  - the state enum (IDLE, LOAD, VERIFY, DONE);
  - `CRC_POLY=16'h1021` and `CRC_INIT=16'hFFFF`;
  - a `crc16_step(crc, bit)` function.
- One sub-module, `scan_crc16`: serial CRC with `clear` and `en` inputs, instanced once and reset between phases.

## Test plan
Benches use `CHAIN_LEN=40`, `WORD_W=32` with a behavioural 40-flop chain model, unless stated otherwise.
1. Load 0xA5A5A5A5, 0x000000FF, `cfg_valid` always high:
   - exactly 2 handshakes; 40 enabled shifts in 41 LOAD cycles;
   - chain = bits 0..39 in order; `pass=1`; `done` at cycle 83.
2. Random words with `cfg_valid` toggled randomly: `scan_en` low on every stall cycle; final chain matches the reference bits; `pass=1`.
3. The chain model flips flop 17 during VERIFY: `pass=0`, `done` still pulses.
4. `start` pulsed again during LOAD and VERIFY: ignored, with no extra handshakes.
5. `rst_n` asserted in mid-LOAD at bit 20: outputs 0 immediately; a subsequent full load passes.
6. `CHAIN_LEN=8`: one handshake with 0xFFFFFF3C; only 8 shifts; chain = 0x3C; `pass=1`.

Source files
------------

// File: rtl/scan_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_cfg_pkg
// Description : Shared definitions for the fabric configuration scan loader:
//               controller state encoding, CRC-16-CCITT constants and the
//               single-bit CRC update function used by the loader and its
//               serial CRC sub-block.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_cfg_pkg;

    // Controller states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } cfg_state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One serial CRC-16-CCITT step: the incoming bit is combined with the
    // register MSB, and the polynomial is folded in when that feedback is 1.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage : scan_cfg_pkg
`default_nettype wire

// File: rtl/scan_crc16.sv
`default_nettype none
// ============================================================================
// Module      : scan_crc16
// Description : Serial CRC-16-CCITT accumulator. One bit is absorbed on each
//               clock where i_en is high; i_clear returns the register to the
//               CRC seed and takes priority over i_en.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset (register -> seed)
//               i_clear  - reload the seed value
//               i_en     - absorb i_bit this cycle
//               i_bit    - serial data bit
//               o_crc    - current CRC register value
// Revision    : 1.0 - initial release
// ============================================================================
module scan_crc16
    import scan_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_INIT;
        end else if (i_clear) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc16_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule : scan_crc16
`default_nettype wire

// File: rtl/scan_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : scan_cfg_loader
// Description : Chip-side driver for the fabric configuration scan chain.
//               Accepts configuration words over valid/ready, shifts them
//               LSB-first into the chain (scan_en only on cycles carrying a
//               real bit), then recirculates the chain once through itself
//               and compares the CRC of the returning bits with the CRC of
//               the loaded bits.
// Ports       : scan_clk  - single clock, shared with the fabric scan cells
//               rst_n     - asynchronous active-low reset
//               start     - one-cycle pulse, begins a load (IDLE only)
//               cfg_data  - configuration word, bit 0 shifted first
//               cfg_valid - cfg_data valid
//               cfg_ready - loader accepts cfg_data this cycle
//               scan_en   - chain shift enable (fabric conn_scan_en)
//               scan_out  - serial data to chain head (fabric conn_scan_in)
//               scan_in   - serial data from chain tail (fabric conn_scan_out)
//               busy      - high while loading or verifying
//               done      - one-cycle pulse when verification completes
//               pass      - result of the last verification (1 = CRCs match)
// Revision    : 1.0 - initial release
// ============================================================================
module scan_cfg_loader
    import scan_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic              scan_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              scan_en,
    output logic              scan_out,
    input  logic              scan_in,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    // ------------------------------------------------------------------------
    // Derived sizes. The last word only carries the bits that remain after
    // the full words; when the chain is shorter than a word this is simply
    // CHAIN_LEN bits of a single word.
    // ------------------------------------------------------------------------
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int TAIL   = CHAIN_LEN - WORD_W * (NWORDS - 1);
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BL_W   = $clog2(WORD_W + 1);
    localparam int WA_W   = $clog2(NWORDS + 1);

    localparam logic [CNT_W-1:0] c_chain_len = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [BL_W-1:0]  c_word_bits = BL_W'(WORD_W);
    localparam logic [BL_W-1:0]  c_tail_bits = BL_W'(TAIL);
    localparam logic [BL_W-1:0]  c_bl_one    = BL_W'(1);
    localparam logic [WA_W-1:0]  c_nwords    = WA_W'(NWORDS);
    localparam logic [WA_W-1:0]  c_last_word = WA_W'(NWORDS - 1);
    localparam logic [WA_W-1:0]  c_wa_one    = WA_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    cfg_state_e        r_state;
    logic [WORD_W-1:0] r_shift;      // word being serialized, bit 0 is next out
    logic [BL_W-1:0]   r_bits_left;  // bits of r_shift still to be shifted
    logic [WA_W-1:0]   r_words_acc;  // words accepted in this load
    logic [CNT_W-1:0]  r_cnt;        // chain bits shifted in the current phase
    logic [15:0]       r_crc_load;   // CRC of the loaded bit stream
    logic              r_pass;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic             w_in_load;
    logic             w_in_verify;
    logic             w_cfg_ready;
    logic             w_hs;
    logic             w_shift;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_load_last;
    logic             w_verify_last;
    logic             w_crc_bit;
    logic             w_crc_en;
    logic             w_crc_clear;
    logic [15:0]      w_crc;
    logic [15:0]      w_crc_next;

    assign w_in_load   = (r_state == ST_LOAD);
    assign w_in_verify = (r_state == ST_VERIFY);

    // Ready while words remain and the current word is on (or past) its last
    // bit, so a new word can be taken on the same edge the old one finishes
    // and a non-stalling source sees no bubbles.
    assign w_cfg_ready = w_in_load && (r_words_acc < c_nwords) &&
                         (r_bits_left <= c_bl_one);
    assign w_hs        = cfg_valid && w_cfg_ready;

    // A LOAD cycle carries a chain bit only when the shifter holds one.
    assign w_shift     = w_in_load && (r_bits_left != '0);

    assign w_cnt_inc     = r_cnt + c_cnt_one;
    assign w_load_last   = w_shift && (w_cnt_inc == c_chain_len);
    assign w_verify_last = w_in_verify && (w_cnt_inc == c_chain_len);

    // Load phase CRCs the outgoing bit; verify phase CRCs the chain tail.
    assign w_crc_bit   = w_in_verify ? scan_in : r_shift[0];
    assign w_crc_en    = w_shift || w_in_verify;
    assign w_crc_clear = ((r_state == ST_IDLE) && start) || w_load_last;

    // The final bit of each phase is absorbed on the same edge the phase
    // ends, so the comparison and the saved load CRC use the look-ahead value.
    assign w_crc_next  = crc16_step(w_crc, w_crc_bit);

    scan_crc16 u_crc (
        .clk     (scan_clk),
        .rst_n   (rst_n),
        .i_clear (w_crc_clear),
        .i_en    (w_crc_en),
        .i_bit   (w_crc_bit),
        .o_crc   (w_crc)
    );

    // ------------------------------------------------------------------------
    // Controller and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_words_acc <= '0;
            r_cnt       <= '0;
            r_crc_load  <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bits_left <= '0;
                        r_words_acc <= '0;
                        r_cnt       <= '0;
                        r_pass      <= 1'b0;
                        r_state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // A handshake replaces the shifter outright; when it
                    // coincides with the last bit of the previous word, that
                    // bit is already on scan_out and is consumed this edge.
                    if (w_hs) begin
                        r_shift     <= cfg_data;
                        r_bits_left <= (r_words_acc == c_last_word) ?
                                       c_tail_bits : c_word_bits;
                        r_words_acc <= r_words_acc + c_wa_one;
                    end else if (w_shift) begin
                        r_shift     <= r_shift >> 1;
                        r_bits_left <= r_bits_left - c_bl_one;
                    end

                    if (w_shift) begin
                        r_cnt <= w_cnt_inc;
                    end

                    if (w_load_last) begin
                        r_crc_load <= w_crc_next;
                        r_cnt      <= '0;
                        r_state    <= ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    r_cnt <= w_cnt_inc;
                    if (w_verify_last) begin
                        r_pass  <= (w_crc_next == r_crc_load);
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. During LOAD the chain signals come straight from the shifter
    // and bit counter flops; during VERIFY the chain is closed on itself.
    // ------------------------------------------------------------------------
    assign cfg_ready = w_cfg_ready;
    assign scan_en   = w_shift || w_in_verify;
    assign scan_out  = w_in_verify ? scan_in : (w_shift & r_shift[0]);
    assign busy      = w_in_load || w_in_verify;
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;

endmodule : scan_cfg_loader
`default_nettype wire

// File: tb/tb_scan_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_cfg_loader
// Description : Self-checking bench for scan_cfg_loader. A 40-flop chain
//               model and a bit-queue reference model check a CHAIN_LEN=40
//               instance; a second CHAIN_LEN=8 instance covers the short
//               chain case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_cfg_loader;

    localparam int CL   = 40;
    localparam int WW   = 32;
    localparam int NW   = 2;
    localparam int TAIL = 8;
    localparam int BL   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 40-bit chain instance ----------------
    logic        rst_n, start, cfg_valid;
    logic [31:0] cfg_data;
    wire         cfg_ready, scan_en, scan_out, scan_in, busy, done, pass;
    logic [CL-1:0] chain = '0;
    bit          flip_req;

    assign scan_in = chain[CL-1];

    scan_cfg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .scan_clk (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .scan_en  (scan_en),
        .scan_out (scan_out),
        .scan_in  (scan_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass)
    );

    // Fabric chain: head is flop 0, tail is flop CL-1. flip_req corrupts
    // flop 17 on one edge to emulate a chain defect.
    always @(posedge clk) begin : chain_model
        logic [CL-1:0] nxt;
        nxt = chain;
        if (scan_en) nxt = {chain[CL-2:0], scan_out};
        if (flip_req) nxt[17] = ~nxt[17];
        chain <= nxt;
    end

    // ---------------- 8-bit chain instance ----------------
    logic        b_start, b_valid;
    logic [31:0] b_data;
    wire         b_ready, b_scan_en, b_scan_out, b_scan_in, b_busy, b_done, b_pass;
    logic [BL-1:0] chain8 = '0;

    assign b_scan_in = chain8[BL-1];

    scan_cfg_loader #(.CHAIN_LEN(BL), .WORD_W(WW)) dut8 (
        .scan_clk (clk),
        .rst_n    (rst_n),
        .start    (b_start),
        .cfg_data (b_data),
        .cfg_valid(b_valid),
        .cfg_ready(b_ready),
        .scan_en  (b_scan_en),
        .scan_out (b_scan_out),
        .scan_in  (b_scan_in),
        .busy     (b_busy),
        .done     (b_done),
        .pass     (b_pass)
    );

    always @(posedge clk) begin
        if (b_scan_en) chain8 <= {chain8[BL-2:0], b_scan_out};
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC-16-CCITT written as long division of the message bit stream.
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
        if (c[15] ^ b) return (c << 1) ^ 16'h1021;
        else           return (c << 1);
    endfunction

    // Expected chain after a load: stream bit k sits k flops from the tail.
    function automatic logic [CL-1:0] chain_of(input logic [31:0] a, input logic [31:0] b);
        logic [CL-1:0] e;
        e = '0;
        for (int k = 0; k < CL; k++) e[CL-1-k] = (k < WW) ? a[k] : b[k-WW];
        return e;
    endfunction

    // ---------------- reference model (bit-queue level) ----------------
    int phase, cyc, hs_cnt, en_cnt, busy_cnt, done_cyc, done_cnt, first_en;
    int shifts_m, words_m, vcnt;
    logic q[$];
    logic [15:0] crc_l, crc_v;
    logic exp_pass;

    task automatic clear_stats();
        cyc = 0; hs_cnt = 0; en_cnt = 0; busy_cnt = 0; done_cyc = 0;
        done_cnt = 0; first_en = 0; shifts_m = 0; words_m = 0; vcnt = 0;
        q.delete();
        crc_l = 16'hFFFF; crc_v = 16'hFFFF;
    endtask

    initial begin
        phase = 0; exp_pass = 1'b0;
        clear_stats();
    end

    always @(negedge clk) begin : monitor
        logic b;
        int   n;
        if (!rst_n) begin
            phase = 0;
            q.delete();
        end else begin
            cyc++;
            if (cfg_valid && cfg_ready) hs_cnt++;
            if (busy) busy_cnt++;
            if (scan_en) begin
                en_cnt++;
                if (first_en == 0) first_en = cyc;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            case (phase)
                0: begin
                    chk1("idle_ready", cfg_ready, 1'b0);
                    chk1("idle_scan_en", scan_en, 1'b0);
                    chk1("idle_busy", busy, 1'b0);
                    chk1("idle_done", done, 1'b0);
                    if (start) phase = 1;
                end
                1: begin
                    chk1("load_busy", busy, 1'b1);
                    chk1("load_done", done, 1'b0);
                    chk1("load_ready", cfg_ready, (words_m < NW) && (q.size() <= 1));
                    chk1("load_scan_en", scan_en, q.size() > 0);
                    if (q.size() > 0) begin
                        b = q.pop_front();
                        chk1("load_scan_out", scan_out, b);
                        crc_l = ref_crc(crc_l, b);
                        shifts_m++;
                    end
                    if (cfg_valid && cfg_ready) begin
                        n = (words_m == NW - 1) ? TAIL : WW;
                        for (int i = 0; i < n; i++) q.push_back(cfg_data[i]);
                        words_m++;
                    end
                    if (shifts_m == CL) begin
                        phase = 2;
                        vcnt  = 0;
                    end
                end
                2: begin
                    chk1("verify_busy", busy, 1'b1);
                    chk1("verify_done", done, 1'b0);
                    chk1("verify_scan_en", scan_en, 1'b1);
                    chk1("verify_loopback", scan_out, scan_in);
                    crc_v = ref_crc(crc_v, scan_in);
                    vcnt++;
                    if (vcnt == CL) begin
                        phase    = 3;
                        exp_pass = (crc_v == crc_l);
                    end
                end
                default: begin
                    chk1("done_pulse", done, 1'b1);
                    chk1("done_busy", busy, 1'b0);
                    chk1("pass_vs_model", pass, exp_pass);
                    phase = 0;
                end
            endcase
        end
    end

    int b_cyc, b_hs, b_en_cnt, b_busy_cnt, b_done_cyc;
    always @(negedge clk) begin
        if (rst_n) begin
            b_cyc++;
            if (b_scan_en) b_en_cnt++;
            if (b_valid && b_ready) b_hs++;
            if (b_busy) b_busy_cnt++;
            if (b_done && b_done_cyc == 0) b_done_cyc = b_cyc;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] w [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full load/verify. Cycle 1 is the cycle carrying the start
    // pulse; sa/sb give cycles with extra start pulses, flip_at the verify
    // shift count at which the chain is corrupted (0 = none).
    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1,
                           input bit rnd, input int sa, input int sb,
                           input int flip_at);
        w[0] = w0;
        w[1] = w1;
        clear_stats();
        for (int k = 1; k <= 400; k++) begin
            start     = (k == 1) || (k == sa) || (k == sb);
            cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_data  = (hs_cnt < 2) ? w[hs_cnt] : $urandom;
            flip_req  = (flip_at > 0) && (phase == 2) && (vcnt == flip_at);
            tick();
            if (done_cnt > 0) break;
        end
        start = 1'b0; cfg_valid = 1'b0; flip_req = 1'b0;
        chkv("done_count", 64'(done_cnt), 64'(1));
    endtask

    initial begin : stim
        logic [31:0] r0, r1;
        logic [7:0]  d8;
        logic [7:0]  e8;
        rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; flip_req = 1'b0;
        b_start = 1'b0; b_valid = 1'b0; b_data = '0;
        #2;
        chk1("rst_cfg_ready", cfg_ready, 1'b0);
        chk1("rst_scan_en", scan_en, 1'b0);
        chk1("rst_scan_out", scan_out, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_pass", pass, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: fixed words, no stalls
        do_load(32'hA5A5A5A5, 32'h000000FF, 1'b0, 0, 0, 0);
        chkv("t1_handshakes", 64'(hs_cnt), 64'(2));
        chkv("t1_scan_en_cycles", 64'(en_cnt), 64'(2 * CL));
        chkv("t1_first_shift_cycle", 64'(first_en), 64'(3));
        chkv("t1_busy_cycles", 64'(busy_cnt), 64'(2 * CL + 1));
        chkv("t1_done_cycle", 64'(done_cyc), 64'(2 * CL + 3));
        chk1("t1_pass", pass, 1'b1);
        chkv("t1_chain", 64'(chain), 64'(chain_of(32'hA5A5A5A5, 32'h000000FF)));

        // 2: random words with random source stalls
        for (int t = 0; t < 3; t++) begin
            r0 = $urandom;
            r1 = $urandom;
            do_load(r0, r1, 1'b1, 0, 0, 0);
            chkv("t2_handshakes", 64'(hs_cnt), 64'(2));
            chk1("t2_pass", pass, 1'b1);
            chkv("t2_chain", 64'(chain), 64'(chain_of(r0, r1)));
        end

        // 3: chain corruption during verify
        do_load(32'h12345678, 32'h0000009A, 1'b0, 0, 0, 3);
        chk1("t3_pass", pass, 1'b0);

        // 4: extra start pulses in LOAD (cycle 10) and VERIFY (cycle 50)
        do_load(32'hDEADBEEF, 32'h00000011, 1'b0, 10, 50, 0);
        chkv("t4_handshakes", 64'(hs_cnt), 64'(2));
        chkv("t4_done_cycle", 64'(done_cyc), 64'(2 * CL + 3));
        chk1("t4_pass", pass, 1'b1);

        // 5: reset in mid-load at bit 20
        clear_stats();
        w[0] = 32'hCAFEF00D; w[1] = 32'h00000055;
        for (int k = 1; k <= 100; k++) begin
            start     = (k == 1);
            cfg_valid = 1'b1;
            cfg_data  = (hs_cnt < 2) ? w[hs_cnt] : 32'h0;
            tick();
            if (shifts_m >= 20) break;
        end
        start = 1'b0;
        chkv("t5_reached_bit20", 64'(shifts_m), 64'(20));
        rst_n = 1'b0;
        #1;
        chk1("t5_rst_cfg_ready", cfg_ready, 1'b0);
        chk1("t5_rst_scan_en", scan_en, 1'b0);
        chk1("t5_rst_scan_out", scan_out, 1'b0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_done", done, 1'b0);
        chk1("t5_rst_pass", pass, 1'b0);
        cfg_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_load(32'h0F0F3C3C, 32'h000000C3, 1'b0, 0, 0, 0);
        chk1("t5_reload_pass", pass, 1'b1);
        chkv("t5_reload_chain", 64'(chain), 64'(chain_of(32'h0F0F3C3C, 32'h000000C3)));

        // 6: 8-bit chain, single word with discarded upper bits
        b_cyc = 0; b_hs = 0; b_en_cnt = 0; b_busy_cnt = 0; b_done_cyc = 0;
        b_start = 1'b1; b_valid = 1'b1; b_data = 32'hFFFFFF3C;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 100 && b_done_cyc == 0; k++) tick();
        b_valid = 1'b0;
        d8 = b_data[7:0];
        for (int k = 0; k < BL; k++) e8[BL-1-k] = d8[k];
        chkv("t6_done_cycle", 64'(b_done_cyc), 64'(2 * BL + 3));
        chkv("t6_handshakes", 64'(b_hs), 64'(1));
        chkv("t6_scan_en_cycles", 64'(b_en_cnt), 64'(2 * BL));
        chkv("t6_busy_cycles", 64'(b_busy_cnt), 64'(2 * BL + 1));
        chkv("t6_chain", 64'(chain8), 64'(e8));
        chk1("t6_pass", b_pass, 1'b1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule : tb_scan_cfg_loader
`default_nettype wire
